// File: rtl/toast_dmem_bridge.sv
// Data-memory bridge: passes low addresses to the RAM and decodes the MMIO window
// (tohost status, 64-bit cycle counter with hi snapshot, console TX FIFO).
module toast_dmem_bridge #(
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] DMEM_addr_i,
    input  logic [3:0]  DMEM_wr_byte_en_i,
    input  logic [31:0] DMEM_wr_data_i,
    input  logic        DMEM_rst_i,
    output logic [31:0] DMEM_rd_data_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_wr_byte_en_o,
    output logic [31:0] ram_wr_data_o,
    input  logic [31:0] ram_rd_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        test_done_o,
    output logic        test_pass_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [9:0] OFF_TOHOST  = 10'h000;
    localparam logic [9:0] OFF_CYC_LO  = 10'h001;
    localparam logic [9:0] OFF_CYC_HI  = 10'h002;
    localparam logic [9:0] OFF_CONSOLE = 10'h003;
    localparam logic [9:0] OFF_STATUS  = 10'h004;

    logic [31:0]   r_tohost;
    logic          r_done;
    logic          r_pass;
    logic [63:0]   r_cycle;
    logic [31:0]   r_shadow;
    logic          r_ovf;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_sel_mmio;
    logic          r_sel_zero;
    logic [31:0]   r_mmio_rd;

    logic          w_is_mmio;
    logic [9:0]    w_off;
    logic          w_tohost_wr;
    logic          w_status_wr;
    logic          w_cyc_lo_rd;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_valid;
    logic          w_full;
    logic [31:0]   w_merged;
    logic [31:0]   w_mmio_rd;

    assign w_is_mmio   = (DMEM_addr_i >= MMIO_BASE);
    assign w_off       = DMEM_addr_i[11:2];
    assign w_tohost_wr = w_is_mmio && (w_off == OFF_TOHOST) && (DMEM_wr_byte_en_i != 4'h0);
    assign w_status_wr = w_is_mmio && (w_off == OFF_STATUS) && DMEM_wr_byte_en_i[1];
    assign w_cyc_lo_rd = w_is_mmio && (w_off == OFF_CYC_LO);

    assign ram_addr_o       = DMEM_addr_i;
    assign ram_wr_data_o    = DMEM_wr_data_i;
    assign ram_wr_byte_en_o = (w_is_mmio || reset_i) ? 4'h0 : DMEM_wr_byte_en_i;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = w_valid && tx_ready_i;
    assign w_push_req = w_is_mmio && (w_off == OFF_CONSOLE) && DMEM_wr_byte_en_i[0] && !reset_i;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    assign tx_valid_o  = w_valid;
    assign tx_data_o   = w_valid ? r_mem[r_rptr] : 8'h00;
    assign test_done_o = r_done;
    assign test_pass_o = r_pass;

    always_comb begin
        w_merged = r_tohost;
        for (int b = 0; b < 4; b++) begin
            if (DMEM_wr_byte_en_i[b]) w_merged[8*b +: 8] = DMEM_wr_data_i[8*b +: 8];
        end
    end

    always_comb begin
        w_mmio_rd = 32'h0;
        case (w_off)
            OFF_TOHOST: w_mmio_rd = r_tohost;
            OFF_CYC_LO: w_mmio_rd = r_cycle[31:0];
            OFF_CYC_HI: w_mmio_rd = r_shadow;
            OFF_STATUS: w_mmio_rd = {22'h0, r_ovf, w_full, 8'(r_count)};
            default:    w_mmio_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tohost   <= 32'h0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_cycle    <= 64'h0;
            r_shadow   <= 32'h0;
            r_ovf      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_sel_mmio <= 1'b0;
            r_sel_zero <= 1'b1;
            r_mmio_rd  <= 32'h0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_cyc_lo_rd) r_shadow <= r_cycle[63:32];
            if (w_tohost_wr) begin
                r_tohost <= w_merged;
                if (w_merged[0])          r_done <= 1'b1;
                if (w_merged == 32'h1)    r_pass <= 1'b1;
            end
            if (w_drop)                                   r_ovf <= 1'b1;
            else if (w_status_wr && DMEM_wr_data_i[9])    r_ovf <= 1'b0;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            r_sel_mmio <= w_is_mmio;
            r_sel_zero <= DMEM_rst_i;
            r_mmio_rd  <= w_mmio_rd;
        end
    end

    // Storage only; occupancy lives in r_count so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= DMEM_wr_data_i[7:0];
    end

    assign DMEM_rd_data_o = r_sel_zero ? 32'h0 : (r_sel_mmio ? r_mmio_rd : ram_rd_data_i);
endmodule

// File: tb/tb_toast_dmem_bridge.sv
// Bench for toast_dmem_bridge: a synchronous-read RAM, a queue-based reference model and
// one task per feature with inline comparisons.
module tb_toast_dmem_bridge;
    localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] A_TOHOST   = MMIO_BASE;
    localparam logic [31:0] A_CYC_LO   = MMIO_BASE + 32'h4;
    localparam logic [31:0] A_CYC_HI   = MMIO_BASE + 32'h8;
    localparam logic [31:0] A_CONSOLE  = MMIO_BASE + 32'hC;
    localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] DMEM_addr_i = 32'h0;
    logic [3:0]  DMEM_wr_byte_en_i = 4'h0;
    logic [31:0] DMEM_wr_data_i = 32'h0;
    logic        DMEM_rst_i = 1'b0;
    logic [31:0] DMEM_rd_data_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_wr_byte_en_o;
    logic [31:0] ram_wr_data_o;
    logic [31:0] ram_rd_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        test_done_o;
    logic        test_pass_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]       exp_q[$];
    logic [31:0]      m_ram [0:4095];
    logic [31:0]      m_tohost;
    logic             m_done, m_pass, m_ovf;
    longint unsigned  m_cycle;
    logic [31:0]      m_shadow;
    logic [31:0]      exp_rd;
    logic [3:0]       exp_ram_be;
    logic [3:0]       obs_ram_be;

    logic [31:0] tb_ram [0:4095];

    toast_dmem_bridge #(.MMIO_BASE(MMIO_BASE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .DMEM_addr_i(DMEM_addr_i), .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i),
        .DMEM_wr_data_i(DMEM_wr_data_i), .DMEM_rst_i(DMEM_rst_i),
        .DMEM_rd_data_o(DMEM_rd_data_o), .ram_addr_o(ram_addr_o),
        .ram_wr_byte_en_o(ram_wr_byte_en_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_rd_data_i(ram_rd_data_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .test_done_o(test_done_o), .test_pass_o(test_pass_o)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM attached to the bridge
    always @(posedge clk) begin
        ram_rd_data_i <= tb_ram[ram_addr_o[13:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wr_byte_en_o[b]) tb_ram[ram_addr_o[13:2]][8*b +: 8] <= ram_wr_data_o[8*b +: 8];
    end

    task automatic do_reset();
        reset_i = 1'b1;
        DMEM_addr_i = 32'h0; DMEM_wr_byte_en_i = 4'h0; DMEM_wr_data_i = 32'h0;
        DMEM_rst_i = 1'b0; tx_ready_i = 1'b0;
        exp_q.delete();
        m_tohost = 32'h0; m_done = 1'b0; m_pass = 1'b0; m_ovf = 1'b0;
        m_cycle = 0; m_shadow = 32'h0; exp_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    // One bus cycle: drive, predict from the model, advance to 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input logic drst, input logic rdy);
        logic        mm;
        logic [9:0]  off;
        logic [31:0] rv;
        logic [31:0] merged;
        DMEM_addr_i = a; DMEM_wr_byte_en_i = be; DMEM_wr_data_i = wd;
        DMEM_rst_i = drst; tx_ready_i = rdy;
        mm  = (a >= MMIO_BASE);
        off = a[11:2];
        exp_ram_be = mm ? 4'h0 : be;
        rv = 32'h0;
        if (!mm) rv = m_ram[a[13:2]];
        else if (off == 10'd0) rv = m_tohost;
        else if (off == 10'd1) rv = m_cycle[31:0];
        else if (off == 10'd2) rv = m_shadow;
        else if (off == 10'd4) rv = {22'h0, m_ovf, exp_q.size() == FIFO_DEPTH, 8'(exp_q.size())};
        exp_rd = drst ? 32'h0 : rv;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (mm && off == 10'd3 && be[0]) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (mm && off == 10'd0 && be != 4'h0) begin
            merged = m_tohost;
            for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
            m_tohost = merged;
            if (merged[0]) m_done = 1'b1;
            if (merged == 32'h1) m_pass = 1'b1;
        end
        if (mm && off == 10'd4 && be[1] && wd[9]) m_ovf = 1'b0;
        if (mm && off == 10'd1) m_shadow = m_cycle[63:32];
        if (!mm) for (int b = 0; b < 4; b++) if (be[b]) m_ram[a[13:2]][8*b +: 8] = wd[8*b +: 8];
        m_cycle = m_cycle + 1;
        @(negedge clk);
        obs_ram_be = ram_wr_byte_en_o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h want 0", DMEM_rd_data_o); end
        n_vec++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h0) begin n_err++; $display("FAIL reset_tx: got v=%b d=%h want 0/00", tx_valid_o, tx_data_o); end
        n_vec++; if (test_done_o !== 1'b0 || test_pass_o !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", test_done_o, test_pass_o); end
        for (int i = 0; i < 3; i++) begin
            step(A_CYC_LO, 4'h0, 32'h0, 1'b0, 1'b0);
            n_vec++; if (DMEM_rd_data_o !== 32'(i)) begin n_err++; $display("FAIL cycle_after_reset%0d: got %h want %h", i, DMEM_rd_data_o, i); end
        end
        step(A_CYC_HI, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", DMEM_rd_data_o); end
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", DMEM_rd_data_o); end
    endtask

    task automatic test_ram();
        step(32'h2000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_vec++; if (obs_ram_be !== 4'hF) begin n_err++; $display("FAIL ram_be: got %h want F", obs_ram_be); end
        step(32'h2000, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rd: got %h want deadbeef", DMEM_rd_data_o); end
        step(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL ram_tohost_untouched: got %h want 0", DMEM_rd_data_o); end
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL ram_status_untouched: got %h want 0", DMEM_rd_data_o); end
        for (int k = 0; k < 16; k++) begin
            step(32'h100 + 32'(4 * k), 4'hF, $urandom, 1'b0, 1'b0);
            n_vec++; if (obs_ram_be !== 4'hF) begin n_err++; $display("FAIL ram_fill_be%0d: got %h want F", k, obs_ram_be); end
        end
    endtask

    task automatic test_tohost();
        do_reset();
        step(A_TOHOST, 4'hF, 32'h1, 1'b0, 1'b0);
        n_vec++; if (test_done_o !== 1'b1 || test_pass_o !== 1'b1) begin n_err++; $display("FAIL tohost_1: got %b%b want 11", test_done_o, test_pass_o); end
        n_vec++; if (obs_ram_be !== 4'h0) begin n_err++; $display("FAIL tohost_ram_be: got %h want 0", obs_ram_be); end
        do_reset();
        step(A_TOHOST, 4'hF, 32'h7, 1'b0, 1'b0);
        n_vec++; if (test_done_o !== 1'b1 || test_pass_o !== 1'b0) begin n_err++; $display("FAIL tohost_7: got %b%b want 10", test_done_o, test_pass_o); end
        do_reset();
        step(A_TOHOST, 4'hF, 32'h2, 1'b0, 1'b0);
        n_vec++; if (test_done_o !== 1'b0 || test_pass_o !== 1'b0) begin n_err++; $display("FAIL tohost_2: got %b%b want 00", test_done_o, test_pass_o); end
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL tohost_same_cycle: got %h want 0", DMEM_rd_data_o); end
        step(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h2) begin n_err++; $display("FAIL tohost_rd2: got %h want 2", DMEM_rd_data_o); end
        step(A_TOHOST, 4'b0001, 32'hFFFF_FF01, 1'b0, 1'b0);
        n_vec++; if (test_done_o !== 1'b1 || test_pass_o !== 1'b1) begin n_err++; $display("FAIL tohost_merge_flags: got %b%b want 11", test_done_o, test_pass_o); end
        step(A_TOHOST, 4'b0010, 32'h0000_AB00, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h1) begin n_err++; $display("FAIL tohost_rd1: got %h want 1", DMEM_rd_data_o); end
        step(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0000_AB01) begin n_err++; $display("FAIL tohost_merge: got %h want 0000ab01", DMEM_rd_data_o); end
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(A_CONSOLE, 4'h1, 32'h41 + 32'(i), 1'b0, 1'b0);
            if (i == 0) begin
                n_vec++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin n_err++; $display("FAIL fifo_first: got v=%b d=%h want 1/41", tx_valid_o, tx_data_o); end
            end
        end
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0000_0308) begin n_err++; $display("FAIL fifo_status_ovf: got %h want 00000308", DMEM_rd_data_o); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41 + 8'(i)) begin n_err++; $display("FAIL fifo_drain%0d: got v=%b d=%h want 1/%h", i, tx_valid_o, tx_data_o, 8'h41 + 8'(i)); end
            step(32'h100, 4'h0, 32'h0, 1'b0, 1'b1);
        end
        n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL fifo_empty: got %b want 0", tx_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) step(A_CONSOLE, 4'h1, 32'h60 + 32'(i), 1'b0, 1'b0);
        step(A_CONSOLE, 4'h1, 32'h70, 1'b0, 1'b1);
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0000_0108) begin n_err++; $display("FAIL b2b_status: got %h want 00000108", DMEM_rd_data_o); end
        step(A_CONSOLE, 4'h1, 32'h71, 1'b0, 1'b0);
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0000_0308) begin n_err++; $display("FAIL b2b_drop: got %h want 00000308", DMEM_rd_data_o); end
        step(A_STATUS, 4'hF, 32'h0000_0200, 1'b0, 1'b0);
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0000_0108) begin n_err++; $display("FAIL ovf_clear: got %h want 00000108", DMEM_rd_data_o); end
        for (int i = 0; i < 8; i++) begin
            want = (i < 7) ? 8'h61 + 8'(i) : 8'h70;
            n_vec++; if (tx_valid_o !== 1'b1 || tx_data_o !== want) begin n_err++; $display("FAIL b2b_drain%0d: got v=%b d=%h want 1/%h", i, tx_valid_o, tx_data_o, want); end
            step(32'h100, 4'h0, 32'h0, 1'b0, 1'b1);
        end
        n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", tx_valid_o); end
    endtask

    task automatic test_cycle_carry();
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.r_cycle;
        m_cycle = 64'h0000_0000_FFFF_FFFE;
        step(A_CYC_LO, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL cyc_lo0: got %h want fffffffe", DMEM_rd_data_o); end
        step(A_CYC_LO, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cyc_lo1: got %h want ffffffff", DMEM_rd_data_o); end
        step(A_CYC_HI, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL cyc_hi_snapshot: got %h want 0", DMEM_rd_data_o); end
        step(A_CYC_LO, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h1) begin n_err++; $display("FAIL cyc_lo_wrapped: got %h want 1", DMEM_rd_data_o); end
        step(A_CYC_HI, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h1) begin n_err++; $display("FAIL cyc_hi_carry: got %h want 1", DMEM_rd_data_o); end
    endtask

    task automatic test_dmem_rst_and_reset();
        step(32'h2000, 4'h0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL dmem_rst: got %h want 0", DMEM_rd_data_o); end
        step(32'h2000, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dmem_rst_release: got %h want deadbeef", DMEM_rd_data_o); end
        for (int i = 0; i < 3; i++) step(A_CONSOLE, 4'h1, 32'h30 + 32'(i), 1'b0, 1'b0);
        n_vec++; if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", tx_valid_o); end
        DMEM_addr_i = 32'h2000; DMEM_wr_byte_en_i = 4'hF; DMEM_wr_data_i = 32'h1234_5678;
        reset_i = 1'b1;
        #1;
        n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b want 0", tx_valid_o); end
        n_vec++; if (ram_wr_byte_en_o !== 4'h0) begin n_err++; $display("FAIL reset_ram_be: got %h want 0", ram_wr_byte_en_o); end
        do_reset();
        step(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", DMEM_rd_data_o); end
        step(32'h2000, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (DMEM_rd_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL reset_ram_kept: got %h want deadbeef", DMEM_rd_data_o); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  be;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            else a = MMIO_BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(a, be, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
            n_vec++; if (DMEM_rd_data_o !== exp_rd) begin n_err++; $display("FAIL rand_rd%0d: addr %h got %h want %h", n, a, DMEM_rd_data_o, exp_rd); end
            n_vec++; if (obs_ram_be !== exp_ram_be) begin n_err++; $display("FAIL rand_ram_be%0d: got %h want %h", n, obs_ram_be, exp_ram_be); end
            n_vec++; if (tx_valid_o !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_valid%0d: got %b want %b", n, tx_valid_o, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                n_vec++; if (tx_data_o !== exp_q[0]) begin n_err++; $display("FAIL rand_head%0d: got %h want %h", n, tx_data_o, exp_q[0]); end
            end
            n_vec++; if (test_done_o !== m_done || test_pass_o !== m_pass) begin n_err++; $display("FAIL rand_flags%0d: got %b%b want %b%b", n, test_done_o, test_pass_o, m_done, m_pass); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tohost();
        test_fifo_overflow();
        test_back_to_back();
        test_cycle_carry();
        test_dmem_rst_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
